// File: rtl/coz_kuyruklu_if.sv
`default_nettype none
// ============================================================================
//  Module   : coz_kuyruklu_if
//  Purpose  : Fetch-side and issue-side handshake bundle of the decode queue.
//  Revision : 1.0 - initial release
// ============================================================================
interface coz_kuyruklu_if #(
    parameter int PS_BIT     = 32,
    parameter int ETIKET_BIT = 4
);
    logic                  cek_bosalt_i;
    logic [31:0]           getir_buyruk_i;
    logic [PS_BIT-1:0]     getir_ps_i;
    logic                  getir_atladi_i;
    logic                  getir_gecerli_i;
    logic                  coz_hazir_o;
    logic                  gecersiz_buyruk_o;
    logic                  yo_hazir_i;
    logic                  uop_gecerli_o;
    logic [PS_BIT-1:0]     uop_ps_o;
    logic [ETIKET_BIT-1:0] uop_etiket_o;
    logic [4:0]            uop_islem_o;
    logic [4:0]            uop_rs1_o;
    logic [4:0]            uop_rs2_o;
    logic                  uop_rs1_en_o;
    logic                  uop_rs2_en_o;
    logic [4:0]            uop_rd_o;
    logic                  uop_rd_alloc_o;
    logic [31:0]           uop_imm_o;
    logic [11:0]           uop_csr_o;
    logic                  uop_atladi_o;

    // Decode stage view
    modport slave (
        input  cek_bosalt_i, getir_buyruk_i, getir_ps_i, getir_atladi_i,
               getir_gecerli_i, yo_hazir_i,
        output coz_hazir_o, gecersiz_buyruk_o, uop_gecerli_o, uop_ps_o,
               uop_etiket_o, uop_islem_o, uop_rs1_o, uop_rs2_o, uop_rs1_en_o,
               uop_rs2_en_o, uop_rd_o, uop_rd_alloc_o, uop_imm_o, uop_csr_o,
               uop_atladi_o
    );

    modport master (
        output cek_bosalt_i, getir_buyruk_i, getir_ps_i, getir_atladi_i,
               getir_gecerli_i, yo_hazir_i,
        input  coz_hazir_o, gecersiz_buyruk_o, uop_gecerli_o, uop_ps_o,
               uop_etiket_o, uop_islem_o, uop_rs1_o, uop_rs2_o, uop_rs1_en_o,
               uop_rs2_en_o, uop_rd_o, uop_rd_alloc_o, uop_imm_o, uop_csr_o,
               uop_atladi_o
    );
endinterface
`default_nettype wire

// File: rtl/coz_kuyruklu.sv
`default_nettype none
// ============================================================================
//  Module   : coz_kuyruklu
//  Purpose  : RV32I decode stage with tagged micro-op FIFO between fetch/issue.
//  Revision : 1.0 - initial release
// ============================================================================
module coz_kuyruklu #(
    parameter int DERINLIK   = 2,
    parameter int ETIKET_BIT = 4,
    parameter int PS_BIT     = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    coz_kuyruklu_if.slave bus
);
    localparam int c_PTR_W = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
    localparam int c_CNT_W = $clog2(DERINLIK + 1);
    localparam logic [c_PTR_W-1:0] c_SON_PTR      = c_PTR_W'(DERINLIK - 1);
    localparam logic [c_CNT_W-1:0] c_DERINLIK_CNT = c_CNT_W'(DERINLIK);

    localparam logic [4:0] c_OP_LUI      = 5'd1;
    localparam logic [4:0] c_OP_AUIPC    = 5'd2;
    localparam logic [4:0] c_OP_JAL      = 5'd3;
    localparam logic [4:0] c_OP_JALR     = 5'd4;
    localparam logic [4:0] c_OP_BEQ      = 5'd5;
    localparam logic [4:0] c_OP_BNE      = 5'd6;
    localparam logic [4:0] c_OP_BLT      = 5'd7;
    localparam logic [4:0] c_OP_BGE      = 5'd8;
    localparam logic [4:0] c_OP_BLTU     = 5'd9;
    localparam logic [4:0] c_OP_BGEU     = 5'd10;
    localparam logic [4:0] c_OP_LW       = 5'd11;
    localparam logic [4:0] c_OP_SW       = 5'd12;
    localparam logic [4:0] c_OP_ADDI     = 5'd13;
    localparam logic [4:0] c_OP_ADD      = 5'd14;
    localparam logic [4:0] c_OP_SUB      = 5'd15;
    localparam logic [4:0] c_OP_OR       = 5'd16;
    localparam logic [4:0] c_OP_AND      = 5'd17;
    localparam logic [4:0] c_OP_XOR      = 5'd18;
    localparam logic [4:0] c_OP_CSRRW    = 5'd19;
    localparam logic [4:0] c_OP_GECERSIZ = 5'd31;

    localparam logic [2:0] c_IMM_YOK = 3'd0;
    localparam logic [2:0] c_IMM_I   = 3'd1;
    localparam logic [2:0] c_IMM_S   = 3'd2;
    localparam logic [2:0] c_IMM_B   = 3'd3;
    localparam logic [2:0] c_IMM_U   = 3'd4;
    localparam logic [2:0] c_IMM_J   = 3'd5;

    typedef struct packed {
        logic [PS_BIT-1:0]     ps;
        logic [ETIKET_BIT-1:0] etiket;
        logic [4:0]            islem;
        logic [4:0]            rs1;
        logic                  rs1_en;
        logic [4:0]            rs2;
        logic                  rs2_en;
        logic [4:0]            rd;
        logic                  rd_alloc;
        logic [31:0]           imm;
        logic [11:0]           csr;
        logic                  atladi;
    } uop_t;

    logic [c_CNT_W-1:0]    r_count;
    logic [c_PTR_W-1:0]    r_wptr;
    logic [c_PTR_W-1:0]    r_rptr;
    logic [ETIKET_BIT-1:0] r_etiket;
    uop_t                  r_mem [DERINLIK];

    logic [31:0] w_b;
    logic [16:0] w_anahtar;
    logic [4:0]  w_islem;
    logic        w_rs1_en;
    logic        w_rs2_en;
    logic        w_rd_yaz;
    logic [2:0]  w_imm_tur;
    uop_t        w_uop;
    uop_t        w_bas;
    logic        w_hazir;
    logic        w_gecerli;
    logic        w_enq;
    logic        w_deq;

    assign w_b       = bus.getir_buyruk_i;
    assign w_anahtar = {w_b[31:25], w_b[14:12], w_b[6:0]};

    // Key is {funct7, funct3, opcode}; '?' marks don't-care bits of each pattern.
    always_comb begin
        w_islem   = c_OP_GECERSIZ;
        w_rs1_en  = 1'b0;
        w_rs2_en  = 1'b0;
        w_rd_yaz  = 1'b0;
        w_imm_tur = c_IMM_YOK;
        casez (w_anahtar)
            17'b???????_???_0110111: begin w_islem = c_OP_LUI;   w_rd_yaz = 1'b1; w_imm_tur = c_IMM_U; end
            17'b???????_???_0010111: begin w_islem = c_OP_AUIPC; w_rd_yaz = 1'b1; w_imm_tur = c_IMM_U; end
            17'b???????_???_1101111: begin w_islem = c_OP_JAL;   w_rd_yaz = 1'b1; w_imm_tur = c_IMM_J; end
            17'b???????_000_1100111: begin w_islem = c_OP_JALR;  w_rd_yaz = 1'b1; w_rs1_en = 1'b1; w_imm_tur = c_IMM_I; end
            17'b???????_000_1100011: begin w_islem = c_OP_BEQ;   w_rs1_en = 1'b1; w_rs2_en = 1'b1; w_imm_tur = c_IMM_B; end
            17'b???????_001_1100011: begin w_islem = c_OP_BNE;   w_rs1_en = 1'b1; w_rs2_en = 1'b1; w_imm_tur = c_IMM_B; end
            17'b???????_100_1100011: begin w_islem = c_OP_BLT;   w_rs1_en = 1'b1; w_rs2_en = 1'b1; w_imm_tur = c_IMM_B; end
            17'b???????_101_1100011: begin w_islem = c_OP_BGE;   w_rs1_en = 1'b1; w_rs2_en = 1'b1; w_imm_tur = c_IMM_B; end
            17'b???????_110_1100011: begin w_islem = c_OP_BLTU;  w_rs1_en = 1'b1; w_rs2_en = 1'b1; w_imm_tur = c_IMM_B; end
            17'b???????_111_1100011: begin w_islem = c_OP_BGEU;  w_rs1_en = 1'b1; w_rs2_en = 1'b1; w_imm_tur = c_IMM_B; end
            17'b???????_010_0000011: begin w_islem = c_OP_LW;    w_rd_yaz = 1'b1; w_rs1_en = 1'b1; w_imm_tur = c_IMM_I; end
            17'b???????_010_0100011: begin w_islem = c_OP_SW;    w_rs1_en = 1'b1; w_rs2_en = 1'b1; w_imm_tur = c_IMM_S; end
            17'b???????_000_0010011: begin w_islem = c_OP_ADDI;  w_rd_yaz = 1'b1; w_rs1_en = 1'b1; w_imm_tur = c_IMM_I; end
            17'b0000000_000_0110011: begin w_islem = c_OP_ADD;   w_rd_yaz = 1'b1; w_rs1_en = 1'b1; w_rs2_en = 1'b1; end
            17'b0100000_000_0110011: begin w_islem = c_OP_SUB;   w_rd_yaz = 1'b1; w_rs1_en = 1'b1; w_rs2_en = 1'b1; end
            17'b0000000_110_0110011: begin w_islem = c_OP_OR;    w_rd_yaz = 1'b1; w_rs1_en = 1'b1; w_rs2_en = 1'b1; end
            17'b0000000_111_0110011: begin w_islem = c_OP_AND;   w_rd_yaz = 1'b1; w_rs1_en = 1'b1; w_rs2_en = 1'b1; end
            17'b0000000_100_0110011: begin w_islem = c_OP_XOR;   w_rd_yaz = 1'b1; w_rs1_en = 1'b1; w_rs2_en = 1'b1; end
            17'b???????_001_1110011: begin w_islem = c_OP_CSRRW; w_rd_yaz = 1'b1; w_rs1_en = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        w_uop          = '0;
        w_uop.ps       = bus.getir_ps_i;
        w_uop.etiket   = r_etiket;
        w_uop.atladi   = bus.getir_atladi_i;
        w_uop.islem    = w_islem;
        w_uop.rs1_en   = w_rs1_en;
        w_uop.rs2_en   = w_rs2_en;
        w_uop.rs1      = w_rs1_en ? w_b[19:15] : 5'd0;
        w_uop.rs2      = w_rs2_en ? w_b[24:20] : 5'd0;
        w_uop.rd       = w_rd_yaz ? w_b[11:7] : 5'd0;
        w_uop.rd_alloc = w_rd_yaz && (w_b[11:7] != 5'd0);
        w_uop.csr      = (w_islem == c_OP_CSRRW) ? w_b[31:20] : 12'd0;
        case (w_imm_tur)
            c_IMM_I: w_uop.imm = {{20{w_b[31]}}, w_b[31:20]};
            c_IMM_S: w_uop.imm = {{20{w_b[31]}}, w_b[31:25], w_b[11:7]};
            c_IMM_B: w_uop.imm = {{19{w_b[31]}}, w_b[31], w_b[7], w_b[30:25], w_b[11:8], 1'b0};
            c_IMM_U: w_uop.imm = {w_b[31:12], 12'd0};
            c_IMM_J: w_uop.imm = {{11{w_b[31]}}, w_b[31], w_b[19:12], w_b[20], w_b[30:21], 1'b0};
            default: w_uop.imm = 32'd0;
        endcase
    end

    function automatic logic [c_PTR_W-1:0] ileri(input logic [c_PTR_W-1:0] p);
        return (p == c_SON_PTR) ? '0 : p + 1'b1;
    endfunction

    // Readiness depends only on registered occupancy, never on yo_hazir_i.
    assign w_hazir   = (r_count < c_DERINLIK_CNT);
    assign w_gecerli = (r_count != '0);
    assign w_enq     = bus.getir_gecerli_i && w_hazir && !bus.cek_bosalt_i && !rst_i;
    assign w_deq     = w_gecerli && bus.yo_hazir_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count  <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_etiket <= '0;
        end else if (bus.cek_bosalt_i) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_enq) begin
                r_wptr   <= ileri(r_wptr);
                r_etiket <= r_etiket + 1'b1;
            end
            if (w_deq) begin
                r_rptr <= ileri(r_rptr);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wptr] <= w_uop;
        end
    end

    // Empty queue presents an all-zero head regardless of stale storage.
    assign w_bas = w_gecerli ? r_mem[r_rptr] : '0;

    assign bus.coz_hazir_o       = w_hazir;
    assign bus.gecersiz_buyruk_o = w_enq && (w_islem == c_OP_GECERSIZ);
    assign bus.uop_gecerli_o     = w_gecerli;
    assign bus.uop_ps_o          = w_bas.ps;
    assign bus.uop_etiket_o      = w_bas.etiket;
    assign bus.uop_islem_o       = w_bas.islem;
    assign bus.uop_rs1_o         = w_bas.rs1;
    assign bus.uop_rs2_o         = w_bas.rs2;
    assign bus.uop_rs1_en_o      = w_bas.rs1_en;
    assign bus.uop_rs2_en_o      = w_bas.rs2_en;
    assign bus.uop_rd_o          = w_bas.rd;
    assign bus.uop_rd_alloc_o    = w_bas.rd_alloc;
    assign bus.uop_imm_o         = w_bas.imm;
    assign bus.uop_csr_o         = w_bas.csr;
    assign bus.uop_atladi_o      = w_bas.atladi;
endmodule
`default_nettype wire

// File: tb/tb_coz_kuyruklu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_coz_kuyruklu
//  Purpose  : Self-checking bench for the coz_kuyruklu decode queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_coz_kuyruklu;
    localparam int c_D = 2;

    localparam logic [31:0] c_ADDI  = 32'h00500093;
    localparam logic [31:0] c_BNE   = 32'hFE209EE3;
    localparam logic [31:0] c_CSRRW = 32'h300312F3;
    localparam logic [31:0] c_LUI   = 32'h123450B7;
    localparam logic [31:0] c_ADD   = 32'h002081B3;

    typedef struct packed {
        logic [31:0] ps;
        logic [3:0]  etiket;
        logic [4:0]  islem;
        logic [4:0]  rs1;
        logic        rs1_en;
        logic [4:0]  rs2;
        logic        rs2_en;
        logic [4:0]  rd;
        logic        rd_alloc;
        logic [31:0] imm;
        logic [11:0] csr;
        logic        atladi;
    } m_uop_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    m_uop_t q[$];
    int     m_etiket = 0;
    bit     started = 1'b0;

    coz_kuyruklu_if #(.PS_BIT(32), .ETIKET_BIT(4)) bus ();

    coz_kuyruklu #(.DERINLIK(c_D), .ETIKET_BIT(4), .PS_BIT(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference decoder written straight from the ISA field definitions.
    function automatic m_uop_t dec(input logic [31:0] w);
        m_uop_t u;
        int     kod;
        int     imm;
        int     sgn;
        bit     wr;
        u   = '0;
        kod = 31;
        imm = 0;
        sgn = w[31] ? 1 : 0;
        case (w[6:0])
            7'h37: kod = 1;
            7'h17: kod = 2;
            7'h6F: kod = 3;
            7'h67: if (w[14:12] == 3'd0) kod = 4;
            7'h63: case (w[14:12])
                       3'd0: kod = 5;  3'd1: kod = 6;  3'd4: kod = 7;
                       3'd5: kod = 8;  3'd6: kod = 9;  3'd7: kod = 10;
                       default: kod = 31;
                   endcase
            7'h03: if (w[14:12] == 3'd2) kod = 11;
            7'h23: if (w[14:12] == 3'd2) kod = 12;
            7'h13: if (w[14:12] == 3'd0) kod = 13;
            7'h33: begin
                if (w[31:25] == 7'h00) begin
                    case (w[14:12])
                        3'd0: kod = 14; 3'd6: kod = 16; 3'd7: kod = 17; 3'd4: kod = 18;
                        default: kod = 31;
                    endcase
                end else if (w[31:25] == 7'h20 && w[14:12] == 3'd0) begin
                    kod = 15;
                end
            end
            7'h73: if (w[14:12] == 3'd1) kod = 19;
            default: kod = 31;
        endcase
        u.islem = kod[4:0];
        if (kod == 31) return u;
        u.rs1_en = (kod >= 4);
        u.rs2_en = (kod >= 5 && kod <= 10) || kod == 12 || (kod >= 14 && kod <= 18);
        wr       = !(kod >= 5 && kod <= 10) && kod != 12;
        if (u.rs1_en) u.rs1 = w[19:15];
        if (u.rs2_en) u.rs2 = w[24:20];
        if (wr) u.rd = w[11:7];
        u.rd_alloc = wr && (w[11:7] != 5'd0);
        case (kod)
            1, 2:        imm = int'(w[31:12]) * 4096;
            3:           imm = -sgn * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                               + int'(w[30:21]) * 2;
            4, 11, 13:   imm = -sgn * 2048 + int'(w[30:20]);
            12:          imm = -sgn * 2048 + int'(w[30:25]) * 32 + int'(w[11:7]);
            5, 6, 7, 8, 9, 10:
                         imm = -sgn * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                               + int'(w[11:8]) * 2;
            default:     imm = 0;
        endcase
        u.imm = imm;
        if (kod == 19) u.csr = w[31:20];
        return u;
    endfunction

    // Model update on the active edge, then full output compare mid-cycle.
    always @(posedge clk) begin
        m_uop_t n;
        m_uop_t e;
        bit     acc;
        bit     exp_ill;
        if (rst) begin
            q.delete();
            m_etiket = 0;
            started  = 1'b1;
        end else if (bus.cek_bosalt_i) begin
            q.delete();
        end else begin
            acc = bus.getir_gecerli_i && (q.size() < c_D);
            if (q.size() > 0 && bus.yo_hazir_i) void'(q.pop_front());
            if (acc) begin
                n        = dec(bus.getir_buyruk_i);
                n.ps     = bus.getir_ps_i;
                n.atladi = bus.getir_atladi_i;
                n.etiket = m_etiket[3:0];
                q.push_back(n);
                m_etiket = (m_etiket + 1) % 16;
            end
        end
        #4;
        if (started) begin
            e = (q.size() > 0) ? q[0] : '0;
            exp_ill = !rst && bus.getir_gecerli_i && !bus.cek_bosalt_i && (q.size() < c_D)
                      && (dec(bus.getir_buyruk_i).islem == 5'd31);
            chk("m_hazir",    bus.coz_hazir_o,       q.size() < c_D);
            chk("m_gecerli",  bus.uop_gecerli_o,     q.size() != 0);
            chk("m_gecersiz", bus.gecersiz_buyruk_o, exp_ill);
            chk("m_ps",       bus.uop_ps_o,          e.ps);
            chk("m_etiket",   bus.uop_etiket_o,      e.etiket);
            chk("m_islem",    bus.uop_islem_o,       e.islem);
            chk("m_rs1",      {bus.uop_rs1_en_o, bus.uop_rs1_o}, {e.rs1_en, e.rs1});
            chk("m_rs2",      {bus.uop_rs2_en_o, bus.uop_rs2_o}, {e.rs2_en, e.rs2});
            chk("m_rd",       {bus.uop_rd_alloc_o, bus.uop_rd_o}, {e.rd_alloc, e.rd});
            chk("m_imm",      bus.uop_imm_o,         e.imm);
            chk("m_csr",      bus.uop_csr_o,         e.csr);
            chk("m_atladi",   bus.uop_atladi_o,      e.atladi);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [31:0] ins, input logic [31:0] ps, input logic atl);
        bus.getir_gecerli_i = v;
        bus.getir_buyruk_i  = ins;
        bus.getir_ps_i      = ps;
        bus.getir_atladi_i  = atl;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        drv(1'b0, 32'd0, 32'd0, 1'b0);
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        drv(1'b0, 32'd0, 32'd0, 1'b0);
        bus.cek_bosalt_i = 1'b0;
        bus.yo_hazir_i   = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #2;
        chk("rst_gecerli",  bus.uop_gecerli_o, 0);
        chk("rst_hazir",    bus.coz_hazir_o, 1);
        chk("rst_gecersiz", bus.gecersiz_buyruk_o, 0);
        chk("rst_imm",      bus.uop_imm_o, 0);

        // addi x1,x0,5
        cyc();
        drv(1'b1, c_ADDI, 32'h100, 1'b1);
        cyc();
        drv(1'b0, 32'd0, 32'd0, 1'b0);
        #2;
        chk("addi_islem", bus.uop_islem_o, 13);
        chk("addi_rs1",   {bus.uop_rs1_en_o, bus.uop_rs1_o}, {1'b1, 5'd0});
        chk("addi_rd",    {bus.uop_rd_alloc_o, bus.uop_rd_o}, {1'b1, 5'd1});
        chk("addi_imm",   bus.uop_imm_o, 5);
        chk("addi_tag",   bus.uop_etiket_o, 0);
        chk("addi_atl",   bus.uop_atladi_o, 1);

        // bne / csrrw / lui back to back, tags 0,1,2
        do_reset();
        drv(1'b1, c_BNE, 32'h200, 1'b0);
        cyc();
        drv(1'b1, c_CSRRW, 32'h204, 1'b0);
        #2;
        chk("bne_islem", bus.uop_islem_o, 6);
        chk("bne_rs",    {bus.uop_rs1_o, bus.uop_rs2_o}, {5'd1, 5'd2});
        chk("bne_imm",   bus.uop_imm_o, 32'hFFFFFFFC);
        chk("bne_alloc", bus.uop_rd_alloc_o, 0);
        chk("bne_tag",   bus.uop_etiket_o, 0);
        cyc();
        drv(1'b1, c_LUI, 32'h208, 1'b0);
        #2;
        chk("csr_islem", bus.uop_islem_o, 19);
        chk("csr_addr",  bus.uop_csr_o, 12'h300);
        chk("csr_rs1rd", {bus.uop_rs1_o, bus.uop_rd_o}, {5'd6, 5'd5});
        chk("csr_tag",   bus.uop_etiket_o, 1);
        cyc();
        drv(1'b0, 32'd0, 32'd0, 1'b0);
        #2;
        chk("lui_islem", bus.uop_islem_o, 1);
        chk("lui_imm",   bus.uop_imm_o, 32'h12345000);
        chk("lui_tag",   bus.uop_etiket_o, 2);

        // Backpressure: three pushes into a two-entry queue
        cyc();
        bus.yo_hazir_i = 1'b0;
        drv(1'b1, c_ADDI, 32'h300, 1'b0);
        cyc();
        drv(1'b1, c_ADD, 32'h304, 1'b1);
        cyc();
        drv(1'b1, c_LUI, 32'h308, 1'b0);
        #2;
        chk("bp_full_hazir", bus.coz_hazir_o, 0);
        cyc();
        bus.yo_hazir_i = 1'b1;
        #2;
        chk("bp_hold_ps", bus.uop_ps_o, 32'h300);
        cyc();
        bus.yo_hazir_i = 1'b0;
        #2;
        chk("bp_deq_ps",    bus.uop_ps_o, 32'h304);
        chk("bp_deq_hazir", bus.coz_hazir_o, 1);
        cyc();
        drv(1'b0, 32'd0, 32'd0, 1'b0);
        #2;
        chk("bp_third_hazir", bus.coz_hazir_o, 0);
        bus.yo_hazir_i = 1'b1;
        cyc();
        #2;
        chk("bp_third_ps",  bus.uop_ps_o, 32'h308);
        chk("bp_third_tag", bus.uop_etiket_o, 5);
        cyc();

        // Illegal word
        drv(1'b1, 32'h00000000, 32'h400, 1'b1);
        #2;
        chk("ill_pulse", bus.gecersiz_buyruk_o, 1);
        cyc();
        drv(1'b0, 32'd0, 32'd0, 1'b0);
        #2;
        chk("ill_pulse_end", bus.gecersiz_buyruk_o, 0);
        chk("ill_islem",     bus.uop_islem_o, 31);
        chk("ill_tag",       bus.uop_etiket_o, 6);
        chk("ill_fields",    {bus.uop_rd_o, bus.uop_rs1_en_o, bus.uop_imm_o}, 38'd0);
        chk("ill_atl",       bus.uop_atladi_o, 1);

        // Flush with a valid input, twice
        do_reset();
        bus.yo_hazir_i = 1'b0;
        drv(1'b1, c_ADDI, 32'h500, 1'b0);
        cyc();
        drv(1'b1, c_ADDI, 32'h504, 1'b0);
        cyc();
        drv(1'b1, c_LUI, 32'h508, 1'b0);
        bus.cek_bosalt_i = 1'b1;
        cyc();
        drv(1'b1, c_BNE, 32'h510, 1'b0);
        #2;
        chk("fl_gecerli", bus.uop_gecerli_o, 0);
        chk("fl_hazir",   bus.coz_hazir_o, 1);
        cyc();
        bus.cek_bosalt_i = 1'b0;
        drv(1'b1, c_ADD, 32'h50C, 1'b0);
        #2;
        chk("fl2_gecerli", bus.uop_gecerli_o, 0);
        cyc();
        drv(1'b0, 32'd0, 32'd0, 1'b0);
        #2;
        chk("fl_next_tag", bus.uop_etiket_o, 2);
        chk("fl_next_ps",  bus.uop_ps_o, 32'h50C);
        bus.yo_hazir_i = 1'b1;
        cyc();

        // Tag wrap over 17 accepted instructions
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drv(1'b1, c_ADD, 32'h600 + 32'(i * 4), i[0]);
            cyc();
            #2;
            chk("wrap_tag", bus.uop_etiket_o, 64'(i % 16));
        end
        chk("add_islem", bus.uop_islem_o, 14);
        chk("add_rs",    {bus.uop_rs1_o, bus.uop_rs2_o, bus.uop_rd_o}, {5'd1, 5'd2, 5'd3});
        drv(1'b0, 32'd0, 32'd0, 1'b0);
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
